// File: rtl/controller_fsm_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side (decodes instruction fields, drives strobes/selects).
interface controller_fsm_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iorD;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic [2:0] aluControl;
    logic       illegalOp;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output iorD, memWrite, irWrite, regDst, memToReg, regWrite,
               aluSrcA, aluSrcB, pcSrc, pcEn, aluControl, illegalOp, state
    );

    modport slave (
        output op, funct, zero,
        input  iorD, memWrite, irWrite, regDst, memToReg, regWrite,
               aluSrcA, aluSrcB, pcSrc, pcEn, aluControl, illegalOp, state
    );
endinterface

// File: rtl/controller_fsm.sv
// Multicycle MIPS-subset main controller: Moore FSM driving datapath selects and write strobes.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, illegal 2 cycles from FETCH; selects registered, pcEn/aluControl/illegalOp combinational.
// No backpressure: advances every cycle; reset abandons the current instruction and masks all write strobes.
module controller_fsm (
    input  logic               clk,
    input  logic               reset,
    controller_fsm_if.master   ctl
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q, state_d;
    logic       ior_sel_q, ior_sel_d;
    logic       mem_write_q, mem_write_d;
    logic       ir_write_q, ir_write_d;
    logic       reg_dst_q, reg_dst_d;
    logic       mem_to_reg_q, mem_to_reg_d;
    logic       reg_write_q, reg_write_d;
    logic       alu_src_a_q, alu_src_a_d;
    logic [1:0] alu_src_b_q, alu_src_b_d;
    logic [1:0] pc_src_q, pc_src_d;
    logic       pc_en_q, pc_en_d;
    logic       branch_q, branch_d;
    logic       op_supported;
    logic [2:0] alu_ctl;

    always_comb begin
        op_supported = 1'b0;
        case (ctl.op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_supported = 1'b1;
            default:                                      op_supported = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            // op is re-sampled here; anything other than lw/sw abandons the access
            S_MEMADR: begin
                if (ctl.op == OP_LW)      state_d = S_MEMRD;
                else if (ctl.op == OP_SW) state_d = S_MEMWR;
                else                      state_d = S_FETCH;
            end
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Selects and strobes are decoded from the next state so they land in the flops
    // together with the state they belong to.
    always_comb begin
        ior_sel_d    = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        pc_src_d     = 2'b00;
        pc_en_d      = 1'b0;
        branch_d     = 1'b0;
        case (state_d)
            S_FETCH: begin
                alu_src_b_d = 2'b01;
                ir_write_d  = 1'b1;
                pc_en_d     = 1'b1;
            end
            S_DECODE: alu_src_b_d = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEMRD: ior_sel_d = 1'b1;
            S_MEMWB: begin
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
            end
            S_MEMWR: begin
                ior_sel_d   = 1'b1;
                mem_write_d = 1'b1;
            end
            S_EXEC: alu_src_a_d = 1'b1;
            S_ALUWB: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            S_ADDIWB: reg_write_d = 1'b1;
            S_BRANCH: begin
                alu_src_a_d = 1'b1;
                pc_src_d    = 2'b01;
                branch_d    = 1'b1;
            end
            S_JUMP: begin
                pc_src_d = 2'b10;
                pc_en_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Output flops reset to the FETCH pattern; write strobes are additionally masked
    // by reset below so nothing writes while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_FETCH;
            ior_sel_q    <= 1'b0;
            mem_write_q  <= 1'b0;
            ir_write_q   <= 1'b1;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_src_a_q  <= 1'b0;
            alu_src_b_q  <= 2'b01;
            pc_src_q     <= 2'b00;
            pc_en_q      <= 1'b1;
            branch_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ior_sel_q    <= ior_sel_d;
            mem_write_q  <= mem_write_d;
            ir_write_q   <= ir_write_d;
            reg_dst_q    <= reg_dst_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            alu_src_a_q  <= alu_src_a_d;
            alu_src_b_q  <= alu_src_b_d;
            pc_src_q     <= pc_src_d;
            pc_en_q      <= pc_en_d;
            branch_q     <= branch_d;
        end
    end

    always_comb begin
        alu_ctl = ALU_ADD;
        if (state_q == S_EXEC) begin
            case (ctl.funct)
                6'b100000: alu_ctl = ALU_ADD;
                6'b100010: alu_ctl = ALU_SUB;
                6'b100100: alu_ctl = ALU_AND;
                6'b100101: alu_ctl = ALU_OR;
                6'b101010: alu_ctl = ALU_SLT;
                default:   alu_ctl = ALU_ADD;
            endcase
        end else if (state_q == S_BRANCH) begin
            alu_ctl = ALU_SUB;
        end
    end

    assign ctl.iorD       = ior_sel_q;
    assign ctl.memWrite   = mem_write_q & reset;
    assign ctl.irWrite    = ir_write_q & reset;
    assign ctl.regDst     = reg_dst_q;
    assign ctl.memToReg   = mem_to_reg_q;
    assign ctl.regWrite   = reg_write_q & reset;
    assign ctl.aluSrcA    = alu_src_a_q;
    assign ctl.aluSrcB    = alu_src_b_q;
    assign ctl.pcSrc      = pc_src_q;
    // Branch PC load follows zero in the same cycle, not a cycle late.
    assign ctl.pcEn       = (pc_en_q | (branch_q & ctl.zero)) & reset;
    assign ctl.aluControl = alu_ctl;
    assign ctl.illegalOp  = (state_q == S_DECODE) & ~op_supported;
    assign ctl.state      = state_q;
endmodule

// File: tb/tb_controller_fsm.sv
// Randomized self-checking bench for controller_fsm against an instruction-level reference model.
module tb_controller_fsm;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   exp_seq[$];

    controller_fsm_if bus ();

    controller_fsm dut (
        .clk   (clk),
        .reset (reset),
        .ctl   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] obs_v;
    assign obs_v = {bus.iorD, bus.memWrite, bus.irWrite, bus.regDst, bus.memToReg,
                    bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.pcEn,
                    bus.aluControl, bus.illegalOp};

    localparam logic [15:0] STROBE_MASK = 16'hDFEF;

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    // Reference: each instruction class visits a fixed list of states from FETCH.
    function automatic void build_seq(input logic [5:0] op);
        case (op)
            6'b100011: exp_seq = '{0, 1, 2, 3, 4};
            6'b101011: exp_seq = '{0, 1, 2, 5};
            6'b000000: exp_seq = '{0, 1, 6, 7};
            6'b001000: exp_seq = '{0, 1, 9, 10};
            6'b000100: exp_seq = '{0, 1, 8};
            6'b000010: exp_seq = '{0, 1, 11};
            default:   exp_seq = '{0, 1};
        endcase
    endfunction

    function automatic logic [15:0] exp_out(input int s, input logic [5:0] op,
                                            input logic [5:0] f, input logic z);
        logic iord, mw, irw, rdst, m2r, rw, srca, pce, ill;
        logic [1:0] srcb, pcs;
        logic [2:0] alu;
        iord = 0; mw = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; srca = 0; pce = 0;
        srcb = 2'b00; pcs = 2'b00; alu = 3'b010;
        case (s)
            0:    begin srcb = 2'b01; irw = 1; pce = 1; end
            1:    srcb = 2'b11;
            2, 9: begin srca = 1; srcb = 2'b10; end
            3:    iord = 1;
            4:    begin m2r = 1; rw = 1; end
            5:    begin iord = 1; mw = 1; end
            6:    srca = 1;
            7:    begin rdst = 1; rw = 1; end
            8:    begin srca = 1; pcs = 2'b01; pce = z; alu = 3'b110; end
            10:   rw = 1;
            11:   begin pcs = 2'b10; pce = 1; end
            default: ;
        endcase
        if (s == 6) begin
            case (f)
                6'b100010: alu = 3'b110;
                6'b100100: alu = 3'b000;
                6'b100101: alu = 3'b001;
                6'b101010: alu = 3'b111;
                default:   alu = 3'b010;
            endcase
        end
        ill = (s == 1) && !is_legal(op);
        return {iord, mw, irw, rdst, m2r, rw, srca, srcb, pcs, pce, alu, ill};
    endfunction

    // Entered shortly after a rising edge with the DUT in FETCH; leaves the same way.
    // zsel: 0/1 force zero, 2 randomizes it.
    task automatic run_instr(input string name, input logic [5:0] op_i,
                             input logic [5:0] f_i, input int zsel);
        logic [15:0] exp_v;
        build_seq(op_i);
        for (int i = 0; i < exp_seq.size(); i++) begin
            int s;
            s = exp_seq[i];
            bus.op    = (s == 1 || s == 2) ? op_i : 6'($urandom);
            bus.funct = (s == 6) ? f_i : 6'($urandom);
            bus.zero  = (zsel == 2) ? 1'($urandom) : 1'(zsel);
            @(negedge clk);
            n_checks++;
            if (bus.state !== 4'(s)) begin
                n_errors++;
                $display("FAIL %s state cyc%0d: got %0d, required %0d", name, i, bus.state, s);
            end
            exp_v = exp_out(s, bus.op, bus.funct, bus.zero);
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL %s outputs cyc%0d st%0d: got %h, required %h", name, i, s, obs_v, exp_v);
            end
            bus.zero = ~bus.zero;
            #1;
            exp_v = exp_out(s, bus.op, bus.funct, bus.zero);
            n_checks++;
            if (obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL %s zero_toggle cyc%0d st%0d: got %h, required %h", name, i, s, obs_v, exp_v);
            end
            @(posedge clk);
            #1;
        end
        bus.op = 6'($urandom);
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_errors++;
            $display("FAIL %s return_fetch: got %0d, required 0", name, bus.state);
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_v;
        reset = 1'b0;
        bus.op = 6'b100011; bus.funct = 6'd0; bus.zero = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_v = exp_out(0, bus.op, bus.funct, bus.zero) & STROBE_MASK;
            n_checks++;
            if (bus.state !== 4'd0 || obs_v !== exp_v) begin
                n_errors++;
                $display("FAIL reset_hold k%0d: got st=%0d out=%h, required st=0 out=%h", k, bus.state, obs_v, exp_v);
            end
        end
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_lw();
        run_instr("lw", 6'b100011, 6'd0, 2);
    endtask

    task automatic test_rtype();
        run_instr("rtype_sub", 6'b000000, 6'b100010, 2);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", 6'b000100, 6'd0, 1);
        run_instr("beq_not_taken", 6'b000100, 6'd0, 0);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_sw", 6'b101011, 6'd0, 2);
        run_instr("b2b_j", 6'b000010, 6'd0, 2);
    endtask

    task automatic test_illegal();
        run_instr("illegal_3f", 6'b111111, 6'd0, 2);
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp_v;
        bus.op = 6'($urandom);
        @(posedge clk); #1 bus.op = 6'b100011;
        @(posedge clk); #1 bus.op = 6'b100011;
        @(posedge clk); #1 bus.op = 6'($urandom);
        n_checks++;
        if (bus.state !== 4'd3) begin
            n_errors++;
            $display("FAIL rstmid reach_memrd: got %0d, required 3", bus.state);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_errors++;
            $display("FAIL rstmid async_state: got %0d, required 0", bus.state);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 1) @(negedge clk);
            exp_v = exp_out(0, bus.op, bus.funct, bus.zero) & STROBE_MASK;
            n_checks++;
            if (obs_v !== exp_v || {bus.irWrite, bus.pcEn, bus.regWrite, bus.memWrite} !== 4'b0) begin
                n_errors++;
                $display("FAIL rstmid strobes k%0d: got %h, required %h", k, obs_v, exp_v);
            end
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus.state !== 4'd0 || {bus.irWrite, bus.pcEn, bus.regWrite, bus.memWrite} !== 4'b0) begin
            n_errors++;
            $display("FAIL rstmid held_edge: got st=%0d out=%h, required st=0 strobes 0", bus.state, obs_v);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        run_instr("rstmid_resume_addi", 6'b001000, 6'd0, 2);
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] functs [5];
        logic [5:0] op_r, f_r;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 80; n++) begin
            int kind;
            kind = $urandom_range(0, 6);
            if (kind < 6) begin
                op_r = ops[kind];
            end else begin
                op_r = 6'($urandom);
                while (is_legal(op_r)) op_r = 6'($urandom);
            end
            f_r = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
            run_instr("random", op_r, f_r, 2);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
